// File: rtl/shift194_ctrl_pkg.sv
// Shared types and constants for the shift194 sequencing controller.
package shift194_pkg;

   localparam int TICK_DIV_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      SHIFT,
      FIN
   } state_t;

   // S encodings seen by the '194-style shift register
   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_LOAD = 2'b01;
   localparam logic [1:0] S_SHR0 = 2'b10;  // toward bit 0, D[0] enters bit 3
   localparam logic [1:0] S_SHR3 = 2'b11;  // toward bit 3, D[1] enters bit 0

endpackage

// File: rtl/shift194_ctrl_if.sv
// Command/status and shift-register pins of the shift194 controller.
// Optional macro SHIFT194_CTRL_PAUSE_EN adds the pause input.
interface shift194_ctrl_if;
   logic       start;
   logic       stop;
   logic [0:3] seed;
   logic       mode;
   logic       dir;
   logic [3:0] steps;
   logic [0:3] q;
   logic [1:0] s;
   logic [1:0] d;
   logic [0:3] par_in;
   logic       busy;
   logic       done;
`ifdef SHIFT194_CTRL_PAUSE_EN
   logic       pause;

   modport master (output start, stop, seed, mode, dir, steps, q, pause,
                   input  s, d, par_in, busy, done);
   modport slave  (input  start, stop, seed, mode, dir, steps, q, pause,
                   output s, d, par_in, busy, done);
`else
   modport master (output start, stop, seed, mode, dir, steps, q,
                   input  s, d, par_in, busy, done);
   modport slave  (input  start, stop, seed, mode, dir, steps, q,
                   output s, d, par_in, busy, done);
`endif
endinterface

// File: rtl/shift194_ctrl_tick_prescaler.sv
// Down-counting period timer: clr restarts the period, en counts down,
// tc_o is high once the period has run out.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   // TICK_DIV-1 wait cycles: reload value counts down to zero inclusive
   localparam logic [7:0] RELOAD = 8'(TICK_DIV - 2);

   logic [7:0] cnt_q, cnt_d;

   // reload, count down while enabled, hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = RELOAD;
      else if (en_i && (cnt_q != 8'd0))
         cnt_d = cnt_q - 8'd1;
   end

   // counter register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= RELOAD;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/shift194_ctrl.sv
// Sequencer driving a '194-style 4-bit shift register: load a seed, then
// shift with ring or Johnson feedback every TICK_DIV cycles.
// Optional macro SHIFT194_CTRL_PAUSE_EN: pause input freezes the WAIT timer.
//
//   state | meaning
//   IDLE  | waiting for start, command fields latched on start
//   LOAD  | S=01, parallel load of the seed
//   WAIT  | S=00, prescaler running
//   SHIFT | one shift with feedback bit on D
//   FIN   | DONE pulse, back to IDLE
module shift194_ctrl
   import shift194_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic               clk_i,
   input  logic               mr_i,
   shift194_ctrl_if.slave     bus
);
   state_t     state_q, state_d;
   logic [0:3] seed_q, seed_d;
   logic       mode_q, mode_d;
   logic       dir_q, dir_d;
   logic [3:0] steps_q, steps_d;
   logic [3:0] cnt_q, cnt_d;
   logic       stop_pend_q, stop_pend_d;
   logic [1:0] s_q, s_d;
   logic [1:0] d_q, d_d;
   logic [0:3] in_q, in_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       pause_w;
   logic       active_w;
   logic       stop_now;
   logic       tick_tc;
   logic       unused_q;

`ifdef SHIFT194_CTRL_PAUSE_EN
   assign pause_w = bus.pause;
`else
   assign pause_w = 1'b0;
`endif

   // only the end bits of Q feed back
   assign unused_q = bus.q[1] ^ bus.q[2];

   assign active_w = (state_q == LOAD) || (state_q == WAIT) || (state_q == SHIFT);
   assign stop_now = stop_pend_q || (active_w && bus.stop);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_i (clk_i),
      .rst_i (mr_i),
      .clr_i (state_q != WAIT),
      .en_i  ((state_q == WAIT) && !pause_w),
      .tc_o  (tick_tc)
   );

   // next state plus outputs for the cycle being entered (registered below)
   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      mode_d      = mode_q;
      dir_d       = dir_q;
      steps_d     = steps_q;
      cnt_d       = cnt_q;
      stop_pend_d = active_w ? stop_now : 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               seed_d  = bus.seed;
               mode_d  = bus.mode;
               dir_d   = bus.dir;
               steps_d = bus.steps;
               cnt_d   = 4'd0;
               state_d = LOAD;
            end
         end
         LOAD:  state_d = WAIT;
         WAIT: begin
            if (tick_tc && !pause_w)
               state_d = SHIFT;
         end
         SHIFT: begin
            cnt_d = cnt_q + 4'd1;
            if (stop_now || ((steps_q != 4'd0) && (cnt_d == steps_q)))
               state_d = FIN;
            else
               state_d = WAIT;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      s_d    = S_HOLD;
      d_d    = 2'b00;
      in_d   = 4'b0000;
      busy_d = (state_d == LOAD) || (state_d == WAIT) || (state_d == SHIFT);
      done_d = (state_d == FIN);
      case (state_d)
         LOAD: begin
            s_d  = S_LOAD;
            in_d = seed_d;
         end
         SHIFT: begin
            // Q is held during WAIT, so sampling it here matches Q in SHIFT
            if (dir_q) begin
               s_d = S_SHR0;
               d_d = {1'b0, bus.q[0] ^ mode_q};
            end else begin
               s_d = S_SHR3;
               d_d = {bus.q[3] ^ mode_q, 1'b0};
            end
         end
         default: ;
      endcase
   end

   // state, command latches and registered outputs; mr_i wins over everything
   always_ff @(posedge clk_i) begin
      if (mr_i) begin
         state_q     <= IDLE;
         seed_q      <= 4'b0000;
         mode_q      <= 1'b0;
         dir_q       <= 1'b0;
         steps_q     <= 4'd0;
         cnt_q       <= 4'd0;
         stop_pend_q <= 1'b0;
         s_q         <= S_HOLD;
         d_q         <= 2'b00;
         in_q        <= 4'b0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         mode_q      <= mode_d;
         dir_q       <= dir_d;
         steps_q     <= steps_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         s_q         <= s_d;
         d_q         <= d_d;
         in_q        <= in_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.s      = s_q;
   assign bus.d      = d_q;
   assign bus.par_in = in_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_shift194_ctrl.sv
// Bench for shift194_ctrl with an attached '194 shift-register model.
// Stimulus pushes hand-computed events; a negedge monitor pops and compares.
// Define SHIFT194_CTRL_PAUSE_EN to also exercise the pause input.
module tb_shift194_ctrl;
   import shift194_pkg::*;

   typedef struct {
      logic [1:0] s;
      logic [0:3] q;
      int         rel;
   } ev_t;

   logic       clk = 1'b0;
   logic       mr;
   int         cyc = 0;
   int         t0 = 0;
   int         tests = 0;
   int         fails = 0;
   logic [0:3] sr_q = 4'b0000;

   ev_t        exp_q[$];
   int         done_exp[$];
   int         busy_exp[$];

   shift194_ctrl_if bus ();

   shift194_ctrl #(.TICK_DIV(4)) dut (
      .clk_i (clk),
      .mr_i  (mr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // '194 behaviour; Q register is not touched by MR
   always @(posedge clk) begin
      case (bus.s)
         S_LOAD: sr_q <= bus.par_in;
         S_SHR3: sr_q <= {bus.d[1], sr_q[0], sr_q[1], sr_q[2]};
         S_SHR0: sr_q <= {sr_q[1], sr_q[2], sr_q[3], bus.d[0]};
         default: ;
      endcase
   end
   assign bus.q = sr_q;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc - t0);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_ev(input logic [1:0] s, input logic [0:3] q, input int rel);
      ev_t e;
      e.s = s;
      e.q = q;
      e.rel = rel;
      exp_q.push_back(e);
   endtask

   task automatic drive_start(input logic [0:3] seed, input logic mode, input logic dir,
                              input logic [3:0] steps);
      bus.seed  = seed;
      bus.mode  = mode;
      bus.dir   = dir;
      bus.steps = steps;
      bus.start = 1'b1;
      t0 = cyc;
      tick(1);
      bus.start = 1'b0;
   endtask

   // monitor: compares each S action, DONE pulse and BUSY run length
   logic [1:0] mon_prev_s = S_HOLD;
   logic [0:3] mon_prev_in = 4'b0000;
   int         mon_busy_run = 0;
   ev_t        mon_e;
   logic       mon_ok;
   always @(negedge clk) begin
      if (mon_prev_s != S_HOLD) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_s_action", int'(mon_prev_s), int'(S_HOLD));
         end else begin
            mon_e = exp_q.pop_front();
            chk("s_code", int'(mon_prev_s), int'(mon_e.s));
            chk("q_value", int'(sr_q), int'(mon_e.q));
            chk("q_timing", cyc - t0, mon_e.rel);
            if (mon_prev_s == S_LOAD)
               chk("load_data", int'(mon_prev_in), int'(mon_e.q));
         end
      end
      if (bus.done) begin
         if (done_exp.size() == 0)
            chk("unexpected_done", 1, 0);
         else
            chk("done_timing", cyc - t0, done_exp.pop_front());
      end
      if (bus.busy) begin
         mon_busy_run++;
      end else if (mon_busy_run != 0) begin
         if (busy_exp.size() == 0)
            chk("unexpected_busy", mon_busy_run, 0);
         else
            chk("busy_length", mon_busy_run, busy_exp.pop_front());
         mon_busy_run = 0;
      end
      mon_ok = 1'b1;
      if (bus.s != S_LOAD && bus.par_in != 4'b0000) mon_ok = 1'b0;
      if ((bus.s == S_HOLD || bus.s == S_LOAD) && bus.d != 2'b00) mon_ok = 1'b0;
      if (bus.s == S_SHR3 && bus.d[0] != 1'b0) mon_ok = 1'b0;
      if (bus.s == S_SHR0 && bus.d[1] != 1'b0) mon_ok = 1'b0;
      if (bus.busy && bus.done) mon_ok = 1'b0;
      chk("output_hygiene", int'(mon_ok), 1);
      mon_prev_s  = bus.s;
      mon_prev_in = bus.par_in;
   end

   initial begin
      mr        = 1'b1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.seed  = 4'b0000;
      bus.mode  = 1'b0;
      bus.dir   = 1'b0;
      bus.steps = 4'd0;
`ifdef SHIFT194_CTRL_PAUSE_EN
      bus.pause = 1'b0;
`endif
      tick(3);
      @(negedge clk);
      chk("reset_s", int'(bus.s), 0);
      chk("reset_d", int'(bus.d), 0);
      chk("reset_in", int'(bus.par_in), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      @(posedge clk);
      #1;
      mr = 1'b0;
      tick(2);

      // ring toward bit 3, 4 steps
      exp_ev(S_LOAD, 4'b1000, 2);
      exp_ev(S_SHR3, 4'b0100, 6);
      exp_ev(S_SHR3, 4'b0010, 10);
      exp_ev(S_SHR3, 4'b0001, 14);
      exp_ev(S_SHR3, 4'b1000, 18);
      done_exp.push_back(18);
      busy_exp.push_back(17);
      drive_start(4'b1000, 1'b0, 1'b0, 4'd4);
      tick(22);

      // Johnson toward bit 0, 8 steps
      exp_ev(S_LOAD, 4'b0000, 2);
      exp_ev(S_SHR0, 4'b0001, 6);
      exp_ev(S_SHR0, 4'b0011, 10);
      exp_ev(S_SHR0, 4'b0111, 14);
      exp_ev(S_SHR0, 4'b1111, 18);
      exp_ev(S_SHR0, 4'b1110, 22);
      exp_ev(S_SHR0, 4'b1100, 26);
      exp_ev(S_SHR0, 4'b1000, 30);
      exp_ev(S_SHR0, 4'b0000, 34);
      done_exp.push_back(34);
      busy_exp.push_back(33);
      drive_start(4'b0000, 1'b1, 1'b1, 4'd8);
      tick(38);

      // free run, STOP 10 cycles after START
      exp_ev(S_LOAD, 4'b1100, 2);
      exp_ev(S_SHR3, 4'b0110, 6);
      exp_ev(S_SHR3, 4'b0011, 10);
      exp_ev(S_SHR3, 4'b1001, 14);
      done_exp.push_back(14);
      busy_exp.push_back(13);
      drive_start(4'b1100, 1'b0, 1'b0, 4'd0);
      tick(9);
      bus.stop = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      tick(12);

      // MR in WAIT after the first shift
      exp_ev(S_LOAD, 4'b1010, 2);
      exp_ev(S_SHR3, 4'b0101, 6);
      busy_exp.push_back(7);
      drive_start(4'b1010, 1'b0, 1'b0, 4'd4);
      tick(6);
      mr = 1'b1;
      tick(1);
      mr = 1'b0;
      @(negedge clk);
      chk("mr_s", int'(bus.s), 0);
      chk("mr_busy", int'(bus.busy), 0);
      chk("mr_done", int'(bus.done), 0);
      tick(5);
      chk("mr_q_frozen", int'(sr_q), int'(4'b0101));

      // cold start after MR, single Johnson step toward bit 0
      exp_ev(S_LOAD, 4'b0011, 2);
      exp_ev(S_SHR0, 4'b0111, 6);
      done_exp.push_back(6);
      busy_exp.push_back(5);
      drive_start(4'b0011, 1'b1, 1'b1, 4'd1);
      tick(10);

      // START re-pulsed in WAIT, SHIFT and FIN is ignored
      exp_ev(S_LOAD, 4'b0001, 2);
      exp_ev(S_SHR3, 4'b1000, 6);
      exp_ev(S_SHR3, 4'b0100, 10);
      done_exp.push_back(10);
      busy_exp.push_back(9);
      drive_start(4'b0001, 1'b0, 1'b0, 4'd2);
      tick(2);
      bus.seed  = 4'b1111;
      bus.steps = 4'd5;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(1);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(4);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(12);

`ifdef SHIFT194_CTRL_PAUSE_EN
      // PAUSE for 5 cycles in the second WAIT period
      exp_ev(S_LOAD, 4'b1000, 2);
      exp_ev(S_SHR3, 4'b0100, 6);
      exp_ev(S_SHR3, 4'b0010, 15);
      done_exp.push_back(15);
      busy_exp.push_back(14);
      drive_start(4'b1000, 1'b0, 1'b0, 4'd2);
      tick(5);
      bus.pause = 1'b1;
      tick(5);
      bus.pause = 1'b0;
      tick(12);
`endif

      chk("events_left", exp_q.size(), 0);
      chk("done_left", done_exp.size(), 0);
      chk("busy_left", busy_exp.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift194_ctrl.md
SHIFT194_CTRL -- requirements
Module: shift194_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4, SHALL set the clock cycles between shift commands (legal 2..255).
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 MR  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  one-cycle request to begin a sequence.
REQ-005 STOP  in  1  request to end a running sequence.
REQ-006 SEED  in  4 [0:3]  pattern loaded into the shift register.
REQ-007 MODE  in  1  0 = ring feedback, 1 = Johnson (inverted) feedback.
REQ-008 DIR  in  1  0 = shift toward bit 3, 1 = shift toward bit 0.
REQ-009 STEPS  in  4  number of shifts; 0 = run until STOP.
REQ-010 Q  in  4 [0:3]  parallel output fed back from the shift register.
REQ-011 S  out  2  shift-register mode: 00 hold, 01 load, 10 shift toward bit 0 (serial in D[0] enters bit 3), 11 shift toward bit 3 (serial in D[1] enters bit 0).
REQ-012 D  out  2  serial inputs to the shift register.
REQ-013 IN  out  4 [0:3]  parallel load data.
REQ-014 BUSY  out  1  high while a sequence is active.
REQ-015 DONE  out  1  one-cycle completion pulse.

Function
REQ-016 S, D, IN, BUSY and DONE SHALL be registered, so the shift register acts on them at the edge ending the cycle in which they are presented.
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT, SHIFT and FIN.
REQ-018 IDLE: START=1 SHALL latch SEED, MODE, DIR and STEPS and go to LOAD; STOP SHALL be ignored in IDLE.
REQ-019 LOAD: S=01, IN=latched SEED, BUSY=1 for 1 cycle, then WAIT.
REQ-020 WAIT: S=00 for TICK_DIV-1 cycles, then SHIFT, giving a shift period of exactly TICK_DIV cycles.
REQ-021 SHIFT: 1 cycle with S=11 when DIR=0 or S=10 when DIR=1.
REQ-022 SHIFT feedback bit: D[1]=Q[3] (DIR=0) or D[0]=Q[0] (DIR=1), inverted when MODE=1; the unused D bit SHALL be 0.
REQ-023 A 4-bit shift counter SHALL increment on each SHIFT. After SHIFT the FSM SHALL go to FIN when the count equals STEPS (STEPS!=0) or a stop is pending; otherwise it SHALL return to WAIT.
REQ-024 STOP=1 in LOAD/WAIT/SHIFT SHALL set a pending-stop flag. The current period completes, so at least one shift occurs after LOAD.
REQ-025 FIN: BUSY=0, DONE=1, S=00 for 1 cycle, then IDLE.
REQ-026 START while BUSY=1 or in FIN SHALL be ignored.
REQ-027 With STEPS=0 the counter SHALL wrap 15->0 without terminating.
REQ-028 Outside LOAD, IN SHALL be 0000; outside SHIFT, D SHALL be 00.

Reset
REQ-029 MR=1 SHALL force IDLE, S=00, D=00, IN=0000, BUSY=0, DONE=0, clear the counter, prescaler and pending-stop flag, and take priority over START/STOP in any state, including mid-sequence.

Configuration
REQ-030 Macro SHIFT194_CTRL_PAUSE_EN defined: a 1-bit input PAUSE SHALL exist. PAUSE=1 in WAIT freezes the prescaler and holds S=00; LOAD, SHIFT and FIN are unaffected.
REQ-031 Macro undefined: the PAUSE port SHALL be absent and behaviour SHALL be identical to PAUSE tied 0.

Structure
REQ-032 Package shift194_pkg SHALL hold the FSM state enum, S-encoding constants (S_HOLD, S_LOAD, S_SHR0, S_SHR3) and the TICK_DIV default.
REQ-033 Sub-module tick_prescaler (counter with clear, enable, terminal-count output) SHALL implement the WAIT timing.

Verification (TICK_DIV=4, shift-register model attached)
REQ-034 SEED=1000, MODE=0, DIR=0, STEPS=4, START -> S=01 one cycle after START; Q sequence 1000, 0100, 0010, 0001, 1000 at 4-cycle spacing; DONE one cycle after the 4th SHIFT.
REQ-035 SEED=0000, MODE=1, DIR=1, STEPS=8 -> Q sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; BUSY high for 1+8*4 cycles.
REQ-036 STEPS=0, STOP 10 cycles after START -> exactly 3 shifts occur, then FIN; DONE=1 once.
REQ-037 MR=1 asserted in WAIT mid-sequence -> next cycle S=00, BUSY=0, DONE=0; Q frozen; a new START behaves as from cold.
REQ-038 START re-pulsed while BUSY=1 -> no reload, no S=01, sequence count unchanged.
REQ-039 With SHIFT194_CTRL_PAUSE_EN, PAUSE held 5 cycles in WAIT -> the next SHIFT is delayed by exactly 5 cycles.
